// File: rtl/data_bus_pkg.sv
// Shared definitions for the core data-bus responder.
//   Region codes for the address decoder (addr[31:28]), MMIO register offsets
//   (addr[3:2]), the compare-register reset value and a small decode helper.
package data_bus_pkg;

  localparam logic [3:0]  RAM_REGION = 4'h0;

  localparam logic [1:0]  OFF_GPO    = 2'd0;
  localparam logic [1:0]  OFF_CYCLE  = 2'd1;
  localparam logic [1:0]  OFF_CMP    = 2'd2;
  localparam logic [1:0]  OFF_STATUS = 2'd3;

  // Compare value out of reset; all-ones so a fresh counter cannot match early.
  localparam logic [31:0] CMP_RST    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_MMIO = 2'd2
  } region_e;

  // RAM takes precedence should the MMIO window ever be placed at region 0.
  function automatic region_e decode_region(input logic [3:0] addr_hi,
                                            input logic [3:0] mmio_hi);
    if (addr_hi == RAM_REGION)   return SEL_RAM;
    else if (addr_hi == mmio_hi) return SEL_MMIO;
    else                         return SEL_NONE;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data RAM for the core data bus.
//   clk    in  rising-edge clock
//   we     in  write enable, data committed on the clock edge
//   idx    in  word index (shared by read and write)
//   wdata  in  write data
//   rdata  out combinational read of mem[idx]; during a write this is the old word
// Contents are deliberately not reset.
module dmem_ram #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_bus_responder.sv
// Responder end of the single-cycle RV32I core data bus.
//   clk        in  system clock, rising edge
//   reset      in  asynchronous active-low reset (clears MMIO state, not RAM)
//   dataWe     in  write strobe for the current access
//   dataAddr   in  byte address, word accesses only
//   datawData  in  write data
//   rData      out read data, combinational from dataAddr
//   gpo        out general-purpose output register
//   irq        out registered compare-match flag (STATUS[0])
// Region 0 is word RAM; the MMIO window holds GPO, a free-running CYCLE counter,
// a CMP register and a sticky write-1-to-clear match flag. Anything else reads 0
// and ignores writes.
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          GPO_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dataWe,
  input  logic [31:0]          dataAddr,
  input  logic [31:0]          datawData,
  output logic [31:0]          rData,
  output logic [GPO_WIDTH-1:0] gpo,
  output logic                 irq
);

  localparam int AW = $clog2(RAM_WORDS);

  region_e              region;
  logic    [1:0]        mmio_off;
  logic    [AW-1:0]     ram_idx;
  logic                 ram_we;
  logic                 mmio_we;
  logic    [31:0]       ram_rdata;

  logic [GPO_WIDTH-1:0] gpo_q;
  logic [31:0]          cycle_cnt;
  logic [31:0]          cmp_q;
  logic                 match_flag;

  // Address bits above the RAM index / MMIO offset alias by design.
  logic                 unused_bits;
  assign unused_bits = ^{dataAddr, datawData};

  assign region   = decode_region(dataAddr[31:28], MMIO_BASE[31:28]);
  assign mmio_off = dataAddr[3:2];
  assign ram_idx  = dataAddr[AW+1:2];
  assign ram_we   = dataWe && (region == SEL_RAM);
  assign mmio_we  = dataWe && (region == SEL_MMIO);

  dmem_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (datawData),
    .rdata (ram_rdata)
  );

  // MMIO registers. The compare uses the pre-increment count and the CMP value
  // held before this edge, so a CMP write only takes effect from the next cycle.
  // A match on the same edge as a W1C keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpo_q      <= '0;
      cycle_cnt  <= '0;
      cmp_q      <= CMP_RST;
      match_flag <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (mmio_we && (mmio_off == OFF_GPO)) gpo_q <= datawData[GPO_WIDTH-1:0];
      if (mmio_we && (mmio_off == OFF_CMP)) cmp_q <= datawData;
      if (cycle_cnt == cmp_q) begin
        match_flag <= 1'b1;
      end else if (mmio_we && (mmio_off == OFF_STATUS) && datawData[0]) begin
        match_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    rData = '0;
    unique case (region)
      SEL_RAM: rData = ram_rdata;
      SEL_MMIO: begin
        unique case (mmio_off)
          OFF_GPO:    rData[GPO_WIDTH-1:0] = gpo_q;
          OFF_CYCLE:  rData = cycle_cnt;
          OFF_CMP:    rData = cmp_q;
          OFF_STATUS: rData[0] = match_flag;
          default:    rData = '0;
        endcase
      end
      default: rData = '0;
    endcase
  end

  assign gpo = gpo_q;
  assign irq = match_flag;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder. The driver sets bus inputs just after
// each rising edge and queues the values it expects; the monitor pops and
// compares them on the following falling edge.
module tb_data_bus_responder;

  localparam logic [31:0] A_GPO    = 32'h1000_0000;
  localparam logic [31:0] A_CYCLE  = 32'h1000_0004;
  localparam logic [31:0] A_CMP    = 32'h1000_0008;
  localparam logic [31:0] A_STATUS = 32'h1000_000C;

  localparam logic [1:0] S_RDATA = 2'd0;
  localparam logic [1:0] S_GPO   = 2'd1;
  localparam logic [1:0] S_IRQ   = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        dataWe;
  logic [31:0] dataAddr;
  logic [31:0] datawData;
  logic [31:0] rData;
  logic [7:0]  gpo;
  logic        irq;

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        q[$];
  logic        smp_vld;
  logic [31:0] cyc_m;
  int          n_chk  = 0;
  int          n_pass = 0;

  data_bus_responder #(
    .RAM_WORDS (64),
    .MMIO_BASE (32'h1000_0000),
    .GPO_WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dataWe    (dataWe),
    .dataAddr  (dataAddr),
    .datawData (datawData),
    .rData     (rData),
    .gpo       (gpo),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    if (smp_vld) begin
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.sel)
          S_GPO:   act = 32'(gpo);
          S_IRQ:   act = 32'(irq);
          default: act = rData;
        endcase
        n_chk++;
        if (act === c.exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    if (reset) cyc_m++;
    #1;
    smp_vld = 1'b0;
    dataWe  = 1'b0;
  endtask

  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    dataWe    = we;
    dataAddr  = a;
    datawData = d;
  endtask

  task automatic expect_(input string nm, input logic [1:0] sel, input logic [31:0] exp);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = exp;
    q.push_back(c);
    smp_vld = 1'b1;
  endtask

  task automatic rd(input logic [31:0] a, input string nm, input logic [31:0] exp);
    bus(1'b0, a, 32'h0);
    expect_(nm, S_RDATA, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] c;
    reset = 1'b0; dataWe = 1'b0; dataAddr = '0; datawData = '0;
    smp_vld = 1'b0; cyc_m = '0;

    // 1: reset values, counter start
    step(); step();
    expect_("rst_gpo", S_GPO, 32'h0);
    expect_("rst_irq", S_IRQ, 32'h0);
    rd(A_CMP, "rst_cmp", 32'hFFFF_FFFF);
    step();
    reset = 1'b1;
    rd(A_CYCLE, "cycle_0", 32'd0);        step();
    rd(A_CYCLE, "cycle_1", 32'd1);        step();
    rd(A_CYCLE, "cycle_2", 32'd2);        step();
    rd(A_STATUS, "rst_status", 32'h0);    step();

    // 2: RAM write/read, old data on same-cycle read, index aliasing
    bus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF); step();
    rd(32'h0000_0010, "ram_rd", 32'hDEAD_BEEF); step();
    bus(1'b1, 32'h0000_0020, 32'h1111_1111); step();
    bus(1'b1, 32'h0000_0020, 32'h2222_2222);
    expect_("ram_old_on_wr", S_RDATA, 32'h1111_1111); step();
    rd(32'h0000_0020, "ram_new", 32'h2222_2222); step();
    bus(1'b1, 32'h0000_0110, 32'h0BAD_F00D); step();
    rd(32'h0000_0010, "ram_alias", 32'h0BAD_F00D); step();
    bus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF); step();
    rd(32'h0000_0010, "ram_rewrite", 32'hDEAD_BEEF); step();

    // 3: GPO and read-only CYCLE
    bus(1'b1, A_GPO, 32'h1234_56A5); step();
    expect_("gpo_pin", S_GPO, 32'h0000_00A5);
    rd(A_GPO, "gpo_rd", 32'h0000_00A5); step();
    rd(32'h1000_0100, "mmio_alias", 32'h0000_00A5); step();
    bus(1'b1, A_CYCLE, 32'h5555_0000); step();
    rd(A_CYCLE, "cycle_ro", cyc_m); step();

    // 4: compare match, sticky, W1C, CMP write latency, set-wins race
    c = cyc_m;
    bus(1'b1, A_CMP, c + 32'd5); step();
    for (int i = 0; i < 5; i++) begin
      expect_("irq_pre_match", S_IRQ, 32'h0); step();
    end
    expect_("irq_match", S_IRQ, 32'h1); step();
    expect_("irq_sticky", S_IRQ, 32'h1);
    rd(A_STATUS, "status_set", 32'h1); step();
    bus(1'b1, A_STATUS, 32'h0000_0001);
    expect_("irq_before_clr", S_IRQ, 32'h1); step();
    expect_("irq_clr", S_IRQ, 32'h0);
    rd(A_STATUS, "status_clr", 32'h0); step();
    c = cyc_m;
    bus(1'b1, A_CMP, c); step();
    expect_("cmp_next_cycle", S_IRQ, 32'h0);
    rd(A_CMP, "cmp_rd", c); step();
    expect_("cmp_no_late", S_IRQ, 32'h0); step();
    c = cyc_m;
    bus(1'b1, A_CMP, c + 32'd2); step();
    step();
    bus(1'b1, A_STATUS, 32'h0000_0001);
    expect_("irq_pre_race", S_IRQ, 32'h0); step();
    expect_("set_wins", S_IRQ, 32'h1); step();

    // 5: unmapped accesses, mid-run reset
    bus(1'b1, 32'h2000_0010, 32'h5555_5555);
    expect_("unmap_wr_rd", S_RDATA, 32'h0); step();
    bus(1'b1, 32'h2000_0000, 32'h0000_00FF); step();
    bus(1'b1, 32'h2000_000C, 32'h0000_0001); step();
    rd(32'h2000_0000, "unmap_rd", 32'h0);
    expect_("unmap_gpo", S_GPO, 32'h0000_00A5);
    expect_("unmap_irq", S_IRQ, 32'h1); step();
    rd(32'h0000_0010, "unmap_ram", 32'hDEAD_BEEF); step();
    reset = 1'b0;
    cyc_m = '0;
    expect_("midrst_gpo", S_GPO, 32'h0);
    expect_("midrst_irq", S_IRQ, 32'h0);
    rd(A_CMP, "midrst_cmp", 32'hFFFF_FFFF); step();
    rd(32'h0000_0010, "ram_keep", 32'hDEAD_BEEF); step();
    reset = 1'b1;
    rd(A_CYCLE, "midrst_cycle", 32'h0); step();

    // 6: counter wrap with CMP=0
    bus(1'b1, A_CMP, 32'h0); step();
    bus(1'b1, A_STATUS, 32'h0000_0001); step();
    force dut.cycle_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.cycle_cnt;
    cyc_m = 32'hFFFF_FFFD;
    for (int i = 0; i < 5; i++) begin
      rd(A_CYCLE, "wrap_cycle", cyc_m);
      expect_("wrap_irq", S_IRQ, (cyc_m == 32'd1) ? 32'h1 : 32'h0);
      step();
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL queue_drain: got %0d expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
